// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
//   XLEN       : datapath width
//   REG_AW     : register address width (32 architectural registers)
//   wb_req_t   : one writeback request (destination + result)
//   busy_vec_t : one busy bit per architectural register
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef logic [31:0] busy_vec_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between execute/decode and the writeback arbiter.
//   ALU path   : alu_valid, alu_rd, alu_data (no backpressure)
//   LSU path   : lsu_valid/lsu_ready handshake, lsu_rd, lsu_data
//   Issue      : issue_valid, issue_rd, issue_ready (WAW stall)
//   Hazard     : rs1_addr/rs2_addr in, rs1_busy/rs2_busy out
//   Write port : wb_en, wb_addr, wb_data to the register file
// Optional (WB_FWD_EN): rs1/rs2 forwarding valid + data from the
// writeback stage.
// slave is the arbiter side, master is the driving environment.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_ready;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
`ifdef WB_FWD_EN
  logic              rs1_fwd_valid;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic              rs2_fwd_valid;
  logic [XLEN-1:0]   rs2_fwd_data;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd,
    input  rs1_addr, rs2_addr,
    output lsu_ready, issue_ready, rs1_busy, rs2_busy,
    output wb_en, wb_addr, wb_data
`ifdef WB_FWD_EN
    , output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd,
    output rs1_addr, rs2_addr,
    input  lsu_ready, issue_ready, rs1_busy, rs2_busy,
    input  wb_en, wb_addr, wb_data
`ifdef WB_FWD_EN
    , input rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests buffering LSU results.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push       : write push_data (caller guarantees !full)
//   pop        : drop the head entry (caller guarantees !empty)
//   full/empty : status from registered pointers only
//   head       : oldest entry, valid when !empty
// DEPTH must be a power of 2 and at least 2; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t push_data,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_req_t     mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU writeback results onto the single register-file
// write port and tracks registers with LSU results still outstanding.
//   clk, rst_n : clock, async active-low reset
//   bus        : regfile_wb_arbiter_if.slave (ALU/LSU/issue inputs,
//                hazard queries, registered write port)
// Priority per cycle: ALU > FIFO head > direct LSU bypass. Bypass only
// when the FIFO is empty and the ALU is idle, so LSU results retire in
// acceptance order. Writes to x0 use the slot but never assert wb_en.
// Optional macro WB_FWD_EN adds rs1/rs2 forwarding from the writeback
// register and masks rsN_busy for the register being cleared this cycle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic      fifo_full;
  logic      fifo_empty;
  wb_req_t   fifo_head;
  wb_req_t   lsu_req;
  logic      fifo_push;
  logic      fifo_pop;
  logic      sel_byp;
  logic      sel_valid;
  wb_req_t   sel_req;
  logic      clr_en;
  logic      issue_fire;
  busy_vec_t busy_q;
  busy_vec_t busy_d;
  logic              wb_en_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [XLEN-1:0]   wb_data_q;

  assign lsu_req    = '{rd: bus.lsu_rd, data: bus.lsu_data};
  assign bus.lsu_ready = !fifo_full;

  assign fifo_pop  = !bus.alu_valid && !fifo_empty;
  assign sel_byp   = !bus.alu_valid && fifo_empty && bus.lsu_valid;
  // An empty FIFO is never full, so a bypass is always an accepted transfer.
  assign fifo_push = bus.lsu_valid && !fifo_full && !sel_byp;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (lsu_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    sel_valid = 1'b1;
    sel_req   = lsu_req;
    if (bus.alu_valid) begin
      sel_req = '{rd: bus.alu_rd, data: bus.alu_data};
    end else if (!fifo_empty) begin
      sel_req = fifo_head;
    end else if (!bus.lsu_valid) begin
      sel_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= sel_valid && (sel_req.rd != '0);
      if (sel_valid) begin
        wb_addr_q <= sel_req.rd;
        wb_data_q <= sel_req.data;
      end
    end
  end

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

  // Scoreboard: the clear happens when the LSU result is selected, so the
  // bit is already low in the cycle the write port carries the value.
  assign clr_en     = (fifo_pop || sel_byp) && (sel_req.rd != '0);
  assign issue_fire = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);
  assign bus.issue_ready = !busy_q[bus.issue_rd];

  always_comb begin
    busy_d = busy_q;
    if (clr_en)     busy_d[sel_req.rd]   = 1'b0;
    if (issue_fire) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef WB_FWD_EN
  assign bus.rs1_busy = busy_q[bus.rs1_addr] && !(clr_en && sel_req.rd == bus.rs1_addr);
  assign bus.rs2_busy = busy_q[bus.rs2_addr] && !(clr_en && sel_req.rd == bus.rs2_addr);
  assign bus.rs1_fwd_valid = wb_en_q && (wb_addr_q == bus.rs1_addr) && (bus.rs1_addr != '0);
  assign bus.rs2_fwd_valid = wb_en_q && (wb_addr_q == bus.rs2_addr) && (bus.rs2_addr != '0);
  assign bus.rs1_fwd_data  = wb_data_q;
  assign bus.rs2_fwd_data  = wb_data_q;
`else
  assign bus.rs1_busy = busy_q[bus.rs1_addr];
  assign bus.rs2_busy = busy_q[bus.rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (FIFO_DEPTH=4).
// Inputs change on the falling edge; registered outputs are sampled 1ns
// after the rising edge, combinational outputs 1ns after input changes.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL reset_wb_en got=%0b exp=0", bus.wb_en); end
    total++;
    if (bus.wb_addr !== 5'd0) begin bad++; $display("FAIL reset_wb_addr got=%0d exp=0", bus.wb_addr); end
    total++;
    if (bus.wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", bus.wb_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL reset_lsu_ready got=%0b exp=1", bus.lsu_ready); end
    total++;
    if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%0b exp=1", bus.issue_ready); end
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL reset_idle_wb_en got=%0b exp=0", bus.wb_en); end
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    bus.rs1_addr  = 5'd5;
    bus.rs2_addr  = 5'd7;
    tick();
    total++;
    if (bus.wb_en !== 1'b1) begin bad++; $display("FAIL alu_wb_en got=%0b exp=1", bus.wb_en); end
    total++;
    if (bus.wb_addr !== 5'd5) begin bad++; $display("FAIL alu_wb_addr got=%0d exp=5", bus.wb_addr); end
    total++;
    if (bus.wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_wb_data got=%h exp=deadbeef", bus.wb_data); end
    total++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
      bad++; $display("FAIL alu_busy got=%0b%0b exp=00", bus.rs1_busy, bus.rs2_busy);
    end
    @(negedge clk);
    idle_inputs();
    tick();
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL alu_idle_wb_en got=%0b exp=0", bus.wb_en); end
  endtask

  task automatic test_issue_bypass();
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    #1;
    total++;
    if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL issue_ready_pre got=%0b exp=1", bus.issue_ready); end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.rs1_addr    = 5'd7;
    bus.rs2_addr    = 5'd0;
    #1;
    total++;
    if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL issue_rs1_busy got=%0b exp=1", bus.rs1_busy); end
    total++;
    if (bus.rs2_busy !== 1'b0) begin bad++; $display("FAIL issue_rs2_busy got=%0b exp=0", bus.rs2_busy); end
    total++;
    if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL issue_waw_stall got=%0b exp=0", bus.issue_ready); end
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd7;
    bus.lsu_data  = 32'h1234;
    #1;
    total++;
    if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL byp_lsu_ready got=%0b exp=1", bus.lsu_ready); end
    tick();
    total++;
    if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd7 || bus.wb_data !== 32'h1234) begin
      bad++; $display("FAIL byp_wb got=%0b/%0d/%h exp=1/7/00001234", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    total++;
    if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL byp_rs1_cleared got=%0b exp=0", bus.rs1_busy); end
    total++;
    if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL byp_issue_ready got=%0b exp=1", bus.issue_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_alu_flood();
    int lsu_idx;
    logic exp_ready;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    lsu_idx = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      bus.alu_valid = (c < 6);
      bus.alu_rd    = 5'(10 + c);
      bus.alu_data  = 32'h100 + 32'(c);
      bus.lsu_valid = (lsu_idx < 5);
      bus.lsu_rd    = 5'(20 + lsu_idx);
      bus.lsu_data  = 32'h200 + 32'(lsu_idx);
      exp_ready     = !(c >= 4 && c <= 6);
      #1;
      total++;
      if (bus.lsu_ready !== exp_ready) begin
        bad++; $display("FAIL flood_ready c=%0d got=%0b exp=%0b", c, bus.lsu_ready, exp_ready);
      end
      if (bus.lsu_valid && exp_ready) lsu_idx++;
      if (c < 6) begin
        exp_rd   = 5'(10 + c);
        exp_data = 32'h100 + 32'(c);
      end else begin
        exp_rd   = 5'(20 + c - 6);
        exp_data = 32'h200 + 32'(c - 6);
      end
      tick();
      total++;
      if (bus.wb_en !== 1'b1 || bus.wb_addr !== exp_rd || bus.wb_data !== exp_data) begin
        bad++; $display("FAIL flood_wb c=%0d got=%0b/%0d/%h exp=1/%0d/%h",
                        c, bus.wb_en, bus.wb_addr, bus.wb_data, exp_rd, exp_data);
      end
    end
    @(negedge clk);
    idle_inputs();
    tick();
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL flood_drained got=%0b exp=0", bus.wb_en); end
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h55;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 32'h66;
    #1;
    total++;
    if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL x0_lsu_ready got=%0b exp=1", bus.lsu_ready); end
    tick();
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL x0_alu_wb_en got=%0b exp=0", bus.wb_en); end
    @(negedge clk);
    idle_inputs();
    tick();
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL x0_lsu_wb_en got=%0b exp=0", bus.wb_en); end
    // x0 entry has drained, so a fresh LSU result must bypass straight through
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd9;
    bus.lsu_data  = 32'h99;
    tick();
    total++;
    if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd9 || bus.wb_data !== 32'h99) begin
      bad++; $display("FAIL x0_after_byp got=%0b/%0d/%h exp=1/9/00000099", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'(11 + i);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      bus.alu_valid   = 1'b1;
      bus.alu_rd      = 5'd1;
      bus.alu_data    = 32'(i);
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd      = 5'(11 + i);
      bus.lsu_data    = 32'h300 + 32'(i);
    end
    @(negedge clk);
    idle_inputs();
    bus.rs1_addr = 5'd12;
    bus.rs2_addr = 5'd13;
    bus.issue_rd = 5'd12;
    #1;
    total++;
    if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
      bad++; $display("FAIL drain_busy_pre got=%0b%0b exp=11", bus.rs1_busy, bus.rs2_busy);
    end
    tick();
    total++;
    if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd11 || bus.wb_data !== 32'h300) begin
      bad++; $display("FAIL drain_first got=%0b/%0d/%h exp=1/11/00000300", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL drain_rst_wb_en got=%0b exp=0", bus.wb_en); end
    total++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.issue_ready !== 1'b1) begin
      bad++; $display("FAIL drain_rst_busy got=%0b%0b ready=%0b exp=00 ready=1",
                      bus.rs1_busy, bus.rs2_busy, bus.issue_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL drain_discard got=%0b exp=0", bus.wb_en); end
    total++;
    if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL drain_lsu_ready got=%0b exp=1", bus.lsu_ready); end
    tick();
    total++;
    if (bus.wb_en !== 1'b0) begin bad++; $display("FAIL drain_discard2 got=%0b exp=0", bus.wb_en); end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    @(negedge clk);
    idle_inputs();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'hA5;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.rs1_addr  = 5'd4;
    bus.rs2_addr  = 5'd3;
    #1;
    total++;
    if (bus.rs2_fwd_valid !== 1'b1 || bus.rs2_fwd_data !== 32'hA5) begin
      bad++; $display("FAIL fwd_rs2 got=%0b/%h exp=1/000000a5", bus.rs2_fwd_valid, bus.rs2_fwd_data);
    end
    total++;
    if (bus.rs1_fwd_valid !== 1'b0) begin bad++; $display("FAIL fwd_rs1 got=%0b exp=0", bus.rs1_fwd_valid); end
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu_write();
    test_issue_bypass();
    test_alu_flood();
    test_rd_zero();
    test_reset_mid_drain();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
